// File: rtl/dca_matrix_lsu_inst_arbiter.sv
// Two-requester round-robin arbiter in front of the matrix LSU instruction port.
// It routes in-order decode and execute completions back to the issuing requester.
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

module dca_matrix_lsu_inst_arbiter #(
    parameter int BW_INST           = `BW_DCA_MATRIX_LSU_INST,
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               clear,
    input  logic               r0_inst_wvalid,
    input  logic [BW_INST-1:0] r0_inst_wdata,
    output logic               r0_inst_wready,
    output logic               r0_inst_decode_finish,
    output logic               r0_inst_execute_finish,
    output logic               r0_busy,
    input  logic               r1_inst_wvalid,
    input  logic [BW_INST-1:0] r1_inst_wdata,
    output logic               r1_inst_wready,
    output logic               r1_inst_decode_finish,
    output logic               r1_inst_execute_finish,
    output logic               r1_busy,
    output logic               lsu_inst_wvalid,
    output logic [BW_INST-1:0] lsu_inst_wdata,
    input  logic               lsu_inst_wready,
    input  logic               lsu_inst_decode_finish,
    input  logic               lsu_inst_execute_finish,
    input  logic               lsu_busy,
    output logic               busy,
    output logic               error
);
    localparam int PW = $clog2(OUTSTANDING_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DECODE} state_t;

    state_t             state_q;
    logic               owner_q, last_grant_q;
    logic [BW_INST-1:0] wdata_q;
    logic               tag_mem_q [OUTSTANDING_DEPTH];
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [CW-1:0]      fifo_count_q, fifo_count_d;
    logic [CW-1:0]      cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic               dec0_q, dec1_q, exe0_q, exe1_q, busy0_q, busy1_q, error_q;

    logic grant0, grant1, accept_ok, push, pop, head;

    // last_grant_q names the requester granted most recently; ties go to the other one.
    assign grant0    = r0_inst_wvalid & (~r1_inst_wvalid | last_grant_q);
    assign grant1    = r1_inst_wvalid & (~r0_inst_wvalid | ~last_grant_q);
    assign accept_ok = (state_q == IDLE) & (fifo_count_q < CW'(OUTSTANDING_DEPTH)) & ~clear;

    assign r0_inst_wready = accept_ok & grant0;
    assign r1_inst_wready = accept_ok & grant1;

    assign push = (state_q == ISSUE) & lsu_inst_wready;
    assign pop  = lsu_inst_execute_finish & (fifo_count_q != '0);
    assign head = tag_mem_q[rptr_q];

    always_comb begin
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        fifo_count_d = fifo_count_q;
        if (r0_inst_wready) cnt0_d = cnt0_d + CW'(1);
        if (r1_inst_wready) cnt1_d = cnt1_d + CW'(1);
        if (pop && !head)   cnt0_d = cnt0_d - CW'(1);
        if (pop && head)    cnt1_d = cnt1_d - CW'(1);
        if (push)           fifo_count_d = fifo_count_d + CW'(1);
        if (pop)            fifo_count_d = fifo_count_d - CW'(1);
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wdata_q      <= '0;
            for (int i = 0; i < OUTSTANDING_DEPTH; i++) tag_mem_q[i] <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            fifo_count_q <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            dec0_q       <= 1'b0;
            dec1_q       <= 1'b0;
            exe0_q       <= 1'b0;
            exe1_q       <= 1'b0;
            busy0_q      <= 1'b0;
            busy1_q      <= 1'b0;
            error_q      <= 1'b0;
        end else if (clear) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wptr_q       <= '0;
            rptr_q       <= '0;
            fifo_count_q <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            dec0_q       <= 1'b0;
            dec1_q       <= 1'b0;
            exe0_q       <= 1'b0;
            exe1_q       <= 1'b0;
            busy0_q      <= 1'b0;
            busy1_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (r0_inst_wready || r1_inst_wready) begin
                        wdata_q      <= r1_inst_wready ? r1_inst_wdata : r0_inst_wdata;
                        owner_q      <= r1_inst_wready;
                        last_grant_q <= r1_inst_wready;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE:       if (lsu_inst_wready) state_q <= WAIT_DECODE;
                WAIT_DECODE: if (lsu_inst_decode_finish) state_q <= IDLE;
                default:     state_q <= IDLE;
            endcase

            dec0_q <= lsu_inst_decode_finish & (state_q == WAIT_DECODE) & ~owner_q;
            dec1_q <= lsu_inst_decode_finish & (state_q == WAIT_DECODE) & owner_q;

            if (push) begin
                tag_mem_q[wptr_q] <= owner_q;
                wptr_q            <= wptr_q + PW'(1);
            end
            if (pop) rptr_q <= rptr_q + PW'(1);

            exe0_q       <= pop & ~head;
            exe1_q       <= pop & head;
            fifo_count_q <= fifo_count_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            // Busy tracks the next count so it rises with the accept and falls with the pop.
            busy0_q      <= (cnt0_d != '0);
            busy1_q      <= (cnt1_d != '0);

            if ((lsu_inst_decode_finish && state_q != WAIT_DECODE) ||
                (lsu_inst_execute_finish && fifo_count_q == '0)) begin
                error_q <= 1'b1;
            end
        end
    end

    assign r0_inst_decode_finish  = dec0_q;
    assign r1_inst_decode_finish  = dec1_q;
    assign r0_inst_execute_finish = exe0_q;
    assign r1_inst_execute_finish = exe1_q;
    assign r0_busy                = busy0_q;
    assign r1_busy                = busy1_q;
    assign lsu_inst_wvalid        = (state_q == ISSUE);
    assign lsu_inst_wdata         = wdata_q;
    assign busy                   = lsu_busy | (state_q != IDLE) | (fifo_count_q != '0);
    assign error                  = error_q;

endmodule

// File: tb/tb_dca_matrix_lsu_inst_arbiter.sv
// Directed self-checking bench for dca_matrix_lsu_inst_arbiter.
module tb_dca_matrix_lsu_inst_arbiter;
    logic       clk = 1'b0;
    logic       rstnn, clear;
    logic       r0_inst_wvalid, r1_inst_wvalid;
    logic [7:0] r0_inst_wdata, r1_inst_wdata;
    logic       r0_inst_wready, r1_inst_wready;
    logic       r0_inst_decode_finish, r1_inst_decode_finish;
    logic       r0_inst_execute_finish, r1_inst_execute_finish;
    logic       r0_busy, r1_busy;
    logic       lsu_inst_wvalid;
    logic [7:0] lsu_inst_wdata;
    logic       lsu_inst_wready, lsu_inst_decode_finish, lsu_inst_execute_finish, lsu_busy;
    logic       busy, error;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dca_matrix_lsu_inst_arbiter #(
        .BW_INST           (8),
        .OUTSTANDING_DEPTH (4)
    ) dut (
        .clk                     (clk),
        .rstnn                   (rstnn),
        .clear                   (clear),
        .r0_inst_wvalid          (r0_inst_wvalid),
        .r0_inst_wdata           (r0_inst_wdata),
        .r0_inst_wready          (r0_inst_wready),
        .r0_inst_decode_finish   (r0_inst_decode_finish),
        .r0_inst_execute_finish  (r0_inst_execute_finish),
        .r0_busy                 (r0_busy),
        .r1_inst_wvalid          (r1_inst_wvalid),
        .r1_inst_wdata           (r1_inst_wdata),
        .r1_inst_wready          (r1_inst_wready),
        .r1_inst_decode_finish   (r1_inst_decode_finish),
        .r1_inst_execute_finish  (r1_inst_execute_finish),
        .r1_busy                 (r1_busy),
        .lsu_inst_wvalid         (lsu_inst_wvalid),
        .lsu_inst_wdata          (lsu_inst_wdata),
        .lsu_inst_wready         (lsu_inst_wready),
        .lsu_inst_decode_finish  (lsu_inst_decode_finish),
        .lsu_inst_execute_finish (lsu_inst_execute_finish),
        .lsu_busy                (lsu_busy),
        .busy                    (busy),
        .error                   (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_r0_wready"}, r0_inst_wready, 0);
        chk({tag, "_r1_wready"}, r1_inst_wready, 0);
        chk({tag, "_pulses"}, {r0_inst_decode_finish, r1_inst_decode_finish,
                               r0_inst_execute_finish, r1_inst_execute_finish}, 0);
        chk({tag, "_rbusy"}, {r0_busy, r1_busy}, 0);
        chk({tag, "_lsu_wvalid"}, lsu_inst_wvalid, 0);
        chk({tag, "_lsu_wdata"}, lsu_inst_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        rstnn = 1'b0; clear = 1'b0;
        r0_inst_wvalid = 1'b0; r1_inst_wvalid = 1'b0;
        r0_inst_wdata = '0; r1_inst_wdata = '0;
        lsu_inst_wready = 1'b0; lsu_inst_decode_finish = 1'b0;
        lsu_inst_execute_finish = 1'b0; lsu_busy = 1'b0;

        // Reset state
        @(negedge clk);
        chk_all_zero("rst");
        #2 rstnn = 1'b1;
        tick();

        // Single request: accept at T
        r0_inst_wvalid = 1'b1; r0_inst_wdata = 8'hA5;
        @(negedge clk);
        chk("t1_r0_wready", r0_inst_wready, 1);
        chk("t1_r1_wready", r1_inst_wready, 0);
        tick();
        r0_inst_wvalid = 1'b0; lsu_inst_wready = 1'b1;              // T+1
        @(negedge clk);
        chk("t1_lsu_wvalid", lsu_inst_wvalid, 1);
        chk("t1_lsu_wdata", lsu_inst_wdata, 8'hA5);
        chk("t1_r0_busy_rise", r0_busy, 1);
        tick();
        lsu_inst_wready = 1'b0;                                     // T+2
        tick();
        lsu_inst_decode_finish = 1'b1;                              // T+3
        tick();
        lsu_inst_decode_finish = 1'b0;                              // T+4
        @(negedge clk);
        chk("t1_dec", {r0_inst_decode_finish, r1_inst_decode_finish}, 2'b10);
        repeat (7) tick();
        lsu_inst_execute_finish = 1'b1;                             // T+11
        @(negedge clk);
        chk("t1_r0_busy_held", r0_busy, 1);
        tick();
        lsu_inst_execute_finish = 1'b0;                             // T+12
        @(negedge clk);
        chk("t1_exe", {r0_inst_execute_finish, r1_inst_execute_finish}, 2'b10);
        tick();                                                     // T+13
        @(negedge clk);
        chk("t1_r0_busy_fall", r0_busy, 0);
        chk("t1_busy_idle", busy, 0);
        tick();

        // Error: execute with empty FIFO, then decode outside WAIT_DECODE
        lsu_inst_execute_finish = 1'b1;
        tick();
        lsu_inst_execute_finish = 1'b0;
        @(negedge clk);
        chk("err_exe_set", error, 1);
        chk("err_exe_nopulse", {r0_inst_execute_finish, r1_inst_execute_finish}, 0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("err_clear", error, 0);
        lsu_inst_decode_finish = 1'b1;
        tick();
        lsu_inst_decode_finish = 1'b0;
        @(negedge clk);
        chk("err_dec_set", error, 1);
        chk("err_dec_nopulse", {r0_inst_decode_finish, r1_inst_decode_finish}, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Contention: grants alternate r0,r1,r0,r1
        for (int i = 0; i < 4; i++) begin
            r0_inst_wvalid = 1'b1; r1_inst_wvalid = 1'b1;
            r0_inst_wdata = 8'(8'h30 + i); r1_inst_wdata = 8'(8'h40 + i);
            @(negedge clk);
            chk("ct_r0_wready", r0_inst_wready, (i % 2) == 0);
            chk("ct_r1_wready", r1_inst_wready, (i % 2) == 1);
            if (i > 0) begin
                chk("ct_dec", {r0_inst_decode_finish, r1_inst_decode_finish},
                    ((i - 1) % 2) == 0 ? 2'b10 : 2'b01);
            end
            tick();
            lsu_inst_wready = 1'b1;
            @(negedge clk);
            chk("ct_lsu_wdata", lsu_inst_wdata, ((i % 2) == 0) ? 32'h30 + i : 32'h40 + i);
            tick();
            lsu_inst_wready = 1'b0; lsu_inst_decode_finish = 1'b1;
            tick();
            lsu_inst_decode_finish = 1'b0;
        end
        r0_inst_wvalid = 1'b0; r1_inst_wvalid = 1'b0;
        @(negedge clk);
        chk("ct_dec_last", {r0_inst_decode_finish, r1_inst_decode_finish}, 2'b01);
        chk("ct_rbusy", {r0_busy, r1_busy}, 2'b11);
        tick();

        // FIFO full: 4 outstanding, 5th request waits for a pop
        r0_inst_wvalid = 1'b1; r0_inst_wdata = 8'h55;
        @(negedge clk);
        chk("ff_no_wready", r0_inst_wready, 0);
        tick();
        lsu_inst_execute_finish = 1'b1;                             // E
        @(negedge clk);
        chk("ff_no_wready_at_e", r0_inst_wready, 0);
        tick();
        lsu_inst_execute_finish = 1'b0;                             // E+1
        @(negedge clk);
        chk("ff_wready_after_pop", r0_inst_wready, 1);
        chk("ff_exe_oldest", {r0_inst_execute_finish, r1_inst_execute_finish}, 2'b10);
        tick();

        // Backpressure for 7 cycles while the remaining r1,r0,r1 complete
        for (int j = 0; j < 7; j++) begin
            r0_inst_wvalid = 1'b1; r1_inst_wvalid = 1'b1;
            r0_inst_wdata = 8'(8'h60 + j); r1_inst_wdata = 8'(8'h70 + j);
            lsu_inst_execute_finish = (j == 0) || (j == 2) || (j == 4);
            @(negedge clk);
            chk("bp_lsu_wvalid", lsu_inst_wvalid, 1);
            chk("bp_lsu_wdata", lsu_inst_wdata, 8'h55);
            chk("bp_no_wready", {r0_inst_wready, r1_inst_wready}, 0);
            chk("bp_r0_exe", r0_inst_execute_finish, j == 3);
            chk("bp_r1_exe", r1_inst_execute_finish, (j == 1) || (j == 5));
            chk("bp_r1_busy", r1_busy, j < 5);
            tick();
        end
        lsu_inst_execute_finish = 1'b0;
        r0_inst_wvalid = 1'b0; r1_inst_wvalid = 1'b0; lsu_inst_wready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_wdata", lsu_inst_wdata, 8'h55);
        tick();
        lsu_inst_wready = 1'b0; lsu_inst_decode_finish = 1'b1;
        tick();
        lsu_inst_decode_finish = 1'b0;
        r1_inst_wvalid = 1'b1; r1_inst_wdata = 8'h77;
        @(negedge clk);
        chk("bp_dec", {r0_inst_decode_finish, r1_inst_decode_finish}, 2'b10);
        chk("ar_r1_wready", r1_inst_wready, 1);
        tick();
        r1_inst_wvalid = 1'b0; lsu_inst_wready = 1'b1;
        tick();
        lsu_inst_wready = 1'b0;

        // Async reset in WAIT_DECODE with 2 outstanding
        @(negedge clk);
        chk("ar_pre_rbusy", {r0_busy, r1_busy}, 2'b11);
        chk("ar_pre_busy", busy, 1);
        #2 rstnn = 1'b0;
        #1;
        chk_all_zero("ar");
        @(negedge clk);
        rstnn = 1'b1;
        tick();
        r0_inst_wvalid = 1'b1; r1_inst_wvalid = 1'b1;
        @(negedge clk);
        chk("ar_first_grant_r0", {r0_inst_wready, r1_inst_wready}, 2'b10);
        tick();
        r0_inst_wvalid = 1'b0; r1_inst_wvalid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
